// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, next-PC select
// encoding and the default reset PC.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIR
  } state_e;

  typedef enum logic [2:0] {
    SEQ,
    HOLD,
    BR,
    JMP,
    JR
  } pc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline stages and the PC sequencer.
// PC_SEQ_JR_EN adds the jump-register request (JumpReg, JumpRegAddr).
interface pc_sequencer_if;

  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchPCPlus4;
  logic [31:0] BranchImm;
  logic        Jump;
  logic [31:0] JumpPCPlus4;
  logic [25:0] JumpIndex;
`ifdef PC_SEQ_JR_EN
  logic        JumpReg;
  logic [31:0] JumpRegAddr;
`endif
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        FetchValid;
  logic        FlushIFID;
  logic        FlushIDEX;
  logic [31:0] RedirectCount;

  modport master (
    output Stall, BranchTaken, BranchPCPlus4, BranchImm, Jump, JumpPCPlus4, JumpIndex,
`ifdef PC_SEQ_JR_EN
    output JumpReg, JumpRegAddr,
`endif
    input  PC, PCPlus4, FetchValid, FlushIFID, FlushIDEX, RedirectCount
  );

  modport slave (
    input  Stall, BranchTaken, BranchPCPlus4, BranchImm, Jump, JumpPCPlus4, JumpIndex,
`ifdef PC_SEQ_JR_EN
    input  JumpReg, JumpRegAddr,
`endif
    output PC, PCPlus4, FetchValid, FlushIFID, FlushIDEX, RedirectCount
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation (branch, jump and, with PC_SEQ_JR_EN, jr).
module pc_target_calc (
  input  logic [31:0] branch_pc_plus4_i,
  input  logic [31:0] branch_imm_i,
  input  logic [3:0]  jump_pc_hi_i,
  input  logic [25:0] jump_index_i,
`ifdef PC_SEQ_JR_EN
  input  logic [29:0] jr_addr_hi_i,
  output logic [31:0] jr_target_o,
`endif
  output logic [31:0] branch_target_o,
  output logic [31:0] jump_target_o
);

  // Offset is in words; the sum wraps modulo 2^32.
  assign branch_target_o = branch_pc_plus4_i + (branch_imm_i << 2);
  assign jump_target_o   = {jump_pc_hi_i, jump_index_i, 2'b00};
`ifdef PC_SEQ_JR_EN
  assign jr_target_o     = {jr_addr_hi_i, 2'b00};
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: PC register, next-PC select, BOOT/RUN/REDIR FSM,
// flush controls and redirect counter. PC_SEQ_JR_EN enables the jr redirect.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic           Clk,
  input logic           Rst,
  pc_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  pc_sel_e     sel;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        redirect, flush_ifid, flush_idex;
  logic        jr_req;
  logic        unused_bits;

  pc_target_calc u_target_calc (
    .branch_pc_plus4_i (bus.BranchPCPlus4),
    .branch_imm_i      (bus.BranchImm),
    .jump_pc_hi_i      (bus.JumpPCPlus4[31:28]),
    .jump_index_i      (bus.JumpIndex),
`ifdef PC_SEQ_JR_EN
    .jr_addr_hi_i      (bus.JumpRegAddr[31:2]),
    .jr_target_o       (jr_target),
`endif
    .branch_target_o   (branch_target),
    .jump_target_o     (jump_target)
  );

`ifdef PC_SEQ_JR_EN
  assign jr_req      = bus.JumpReg;
  assign unused_bits = ^{bus.JumpPCPlus4[27:0], bus.JumpRegAddr[1:0]};
`else
  assign jr_req      = 1'b0;
  assign jr_target   = 32'h0;
  assign unused_bits = ^bus.JumpPCPlus4[27:0];
`endif

  always_comb begin
    sel        = SEQ;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    // BOOT ignores every request; the older EX branch beats any ID redirect.
    if (state_q == BOOT) begin
      sel = HOLD;
    end else if (bus.BranchTaken) begin
      sel        = BR;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (jr_req) begin
      sel        = JR;
      flush_ifid = 1'b1;
    end else if (bus.Jump) begin
      sel        = JMP;
      flush_ifid = 1'b1;
    end else if (bus.Stall) begin
      sel = HOLD;
    end
  end

  assign redirect = (sel == BR) || (sel == JMP) || (sel == JR);

  always_comb begin
    unique case (sel)
      SEQ:     pc_d = pc_q + 32'd4;
      HOLD:    pc_d = pc_q;
      BR:      pc_d = branch_target;
      JMP:     pc_d = jump_target;
      JR:      pc_d = jr_target;
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN,
      REDIR:   state_d = redirect ? REDIR : RUN;
      default: state_d = BOOT;
    endcase
  end

  assign count_d = count_q + {31'b0, redirect};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign bus.PC            = pc_q;
  assign bus.PCPlus4       = pc_q + 32'd4;
  assign bus.FetchValid    = (state_q != BOOT);
  assign bus.FlushIFID     = flush_ifid;
  assign bus.FlushIDEX     = flush_idex;
  assign bus.RedirectCount = count_q;

endmodule
